// File: rtl/muldiv_pkg.sv
// Shared encodings and defaults for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MULT_RUN = 2'd1,
        DIV_RUN  = 2'd2,
        CLEAR    = 2'd3
    } muldiv_state_e;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int unsigned DEF_TIMEOUT_CYCLES = 64;
    localparam int unsigned DEF_CNT_W          = 7;

endpackage

// File: rtl/muldiv_watchdog.sv
// Completion watchdog: clear/enable counter that flags the last permitted cycle.
module muldiv_watchdog
    import muldiv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic             expired
);

    // Count holds k-1 during the k-th enabled cycle, so expiry marks the final allowed cycle.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear dominates enable.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer between the control unit and the shared mult/div units; owns HI/LO.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic        op_sel,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        op_ready,
    output logic        mult_start,
    input  logic        mult_done,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    output logic        div_start,
    input  logic        div_done,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    output logic [31:0] opa_q,
    output logic [31:0] opb_q,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic        timeout
);

    muldiv_state_e state_q, state_d;
    logic          sel_q, sel_d;
    logic [31:0]   opa_d, opb_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic          done_q, done_d;
    logic          div_zero_q, div_zero_d;
    logic          timeout_q, timeout_d;
    logic          wd_clr, wd_en, wd_expired;
    logic          unit_done;

    muldiv_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    assign unit_done = (sel_q == OP_MULT) ? mult_done : div_done;

    // Next-state, operand latch, HI/LO commit and pulse generation.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;
        timeout_d  = 1'b0;
        wd_clr     = 1'b0;
        wd_en      = 1'b0;
        unique case (state_q)
            IDLE: begin
                wd_clr = 1'b1;
                if (op_valid) begin
                    opa_d = op_a;
                    opb_d = op_b;
                    sel_d = op_sel;
                    if (op_sel == OP_MULT) begin
                        state_d = MULT_RUN;
                    end else if (op_b != '0) begin
                        state_d = DIV_RUN;
                    end else begin
                        div_zero_d = 1'b1;
                    end
                end
            end
            MULT_RUN: begin
                wd_en = 1'b1;
                if (mult_done) begin
                    hi_d    = mult_hi;
                    lo_d    = mult_lo;
                    done_d  = 1'b1;
                    state_d = CLEAR;
                end else if (wd_expired) begin
                    timeout_d = 1'b1;
                    state_d   = CLEAR;
                end
            end
            DIV_RUN: begin
                wd_en = 1'b1;
                if (div_done) begin
                    hi_d    = div_hi;
                    lo_d    = div_lo;
                    done_d  = 1'b1;
                    state_d = CLEAR;
                end else if (wd_expired) begin
                    timeout_d = 1'b1;
                    state_d   = CLEAR;
                end
            end
            CLEAR: begin
                if (!unit_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            sel_q      <= OP_MULT;
            opa_q      <= '0;
            opb_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            timeout_q  <= timeout_d;
        end
    end

    assign op_ready   = (state_q == IDLE);
    assign busy       = ~op_ready;
    assign mult_start = (state_q == MULT_RUN);
    assign div_start  = (state_q == DIV_RUN);
    assign hi         = hi_q;
    assign lo         = lo_q;
    assign done       = done_q;
    assign div_zero   = div_zero_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_sel;
    logic [31:0] op_a, op_b;
    logic        op_ready, mult_start, div_start;
    logic        mult_done, div_done;
    logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
    logic [31:0] opa_q, opb_q, hi, lo;
    logic        busy, done, div_zero, timeout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_ctrl #(
        .TIMEOUT_CYCLES (64),
        .CNT_W          (7)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .op_valid   (op_valid),
        .op_sel     (op_sel),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_ready   (op_ready),
        .mult_start (mult_start),
        .mult_done  (mult_done),
        .mult_hi    (mult_hi),
        .mult_lo    (mult_lo),
        .div_start  (div_start),
        .div_done   (div_done),
        .div_hi     (div_hi),
        .div_lo     (div_lo),
        .opa_q      (opa_q),
        .opb_q      (opb_q),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .timeout    (timeout)
    );

    // Starts must never be high together once out of the initial unknown state.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            checks++;
            if ((mult_start & div_start) !== 1'b0) begin
                failures++;
                $display("FAIL start_excl: mult_start=%b div_start=%b required not both 1", mult_start, div_start);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; op_valid = 1'b1; op_sel = 1'b0; op_a = 32'd5; op_b = 32'd6;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({op_ready, busy, mult_start, div_start, done, div_zero, timeout} !== 7'b1000000) begin
                failures++;
                $display("FAIL reset_ctrl: rdy/busy/ms/ds/done/dz/to=%b required 1000000",
                         {op_ready, busy, mult_start, div_start, done, div_zero, timeout});
            end
            checks++;
            if ({hi, lo, opa_q, opb_q} !== 128'd0) begin
                failures++;
                $display("FAIL reset_regs: hi=%h lo=%h opa=%h opb=%h required all 0", hi, lo, opa_q, opb_q);
            end
        end
        op_valid = 1'b0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_mult;
        op_valid = 1'b1; op_sel = 1'b0; op_a = 32'hFFFFFFFB; op_b = 32'd3;
        tick();
        op_valid = 1'b0;
        checks++;
        if ({mult_start, div_start, op_ready, busy} !== 4'b1001 || opa_q !== 32'hFFFFFFFB || opb_q !== 32'd3) begin
            failures++;
            $display("FAIL mult_accept: ms=%b ds=%b rdy=%b busy=%b opa=%h opb=%h required 1 0 0 1 fffffffb 00000003",
                     mult_start, div_start, op_ready, busy, opa_q, opb_q);
        end
        for (int k = 2; k <= 33; k++) begin
            tick();
            checks++;
            if (mult_start !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL mult_hold: cycle %0d ms=%b done=%b required 1 0", k, mult_start, done);
            end
        end
        mult_done = 1'b1; mult_hi = 32'hFFFFFFFF; mult_lo = 32'hFFFFFFF1;
        tick();
        checks++;
        if (done !== 1'b1 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1 || mult_start !== 1'b0) begin
            failures++;
            $display("FAIL mult_commit: done=%b hi=%h lo=%h ms=%b required 1 ffffffff fffffff1 0",
                     done, hi, lo, mult_start);
        end
        mult_done = 1'b0;
        tick();
        checks++;
        if (op_ready !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL mult_idle: rdy=%b done=%b required 1 0", op_ready, done);
        end
    endtask

    task automatic test_div;
        op_valid = 1'b1; op_sel = 1'b1; op_a = 32'd7; op_b = 32'd2;
        tick();
        op_valid = 1'b0;
        checks++;
        if (div_start !== 1'b1 || mult_start !== 1'b0) begin
            failures++;
            $display("FAIL div_start: ds=%b ms=%b required 1 0", div_start, mult_start);
        end
        div_done = 1'b1; div_hi = 32'd1; div_lo = 32'd3;
        tick();
        checks++;
        if (done !== 1'b1 || hi !== 32'd1 || lo !== 32'd3 || div_start !== 1'b0) begin
            failures++;
            $display("FAIL div_commit: done=%b hi=%h lo=%h ds=%b required 1 1 3 0", done, hi, lo, div_start);
        end
        div_done = 1'b0;
        tick();
        // Divide by zero: rejected straight from IDLE.
        op_valid = 1'b1; op_sel = 1'b1; op_a = 32'd7; op_b = 32'd0;
        tick();
        op_valid = 1'b0;
        checks++;
        if ({div_zero, div_start, done, op_ready} !== 4'b1001 || hi !== 32'd1 || lo !== 32'd3) begin
            failures++;
            $display("FAIL div_zero_pulse: dz=%b ds=%b done=%b rdy=%b hi=%h lo=%h required 1 0 0 1 1 3",
                     div_zero, div_start, done, op_ready, hi, lo);
        end
        tick();
        checks++;
        if (div_zero !== 1'b0 || div_start !== 1'b0) begin
            failures++;
            $display("FAIL div_zero_after: dz=%b ds=%b required 0 0", div_zero, div_start);
        end
    endtask

    task automatic test_timeout;
        op_valid = 1'b1; op_sel = 1'b0; op_a = 32'd2; op_b = 32'd2;
        tick();
        op_valid = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            checks++;
            if (mult_start !== 1'b1 || timeout !== 1'b0) begin
                failures++;
                $display("FAIL to_run: cycle %0d ms=%b to=%b required 1 0", k, mult_start, timeout);
            end
            tick();
        end
        checks++;
        if ({timeout, done, mult_start} !== 3'b100 || hi !== 32'd1 || lo !== 32'd3) begin
            failures++;
            $display("FAIL to_pulse: to=%b done=%b ms=%b hi=%h lo=%h required 1 0 0 1 3",
                     timeout, done, mult_start, hi, lo);
        end
        tick();
        checks++;
        if (op_ready !== 1'b1 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL to_idle: rdy=%b to=%b required 1 0", op_ready, timeout);
        end
        // Done arriving in the final watchdog cycle wins over expiry.
        op_valid = 1'b1; op_sel = 1'b0;
        tick();
        op_valid = 1'b0;
        for (int k = 1; k < 64; k++) tick();
        mult_done = 1'b1; mult_hi = 32'h0000_00AB; mult_lo = 32'h0000_00CD;
        tick();
        checks++;
        if ({done, timeout} !== 2'b10 || hi !== 32'hAB || lo !== 32'hCD) begin
            failures++;
            $display("FAIL to_race: done=%b to=%b hi=%h lo=%h required 1 0 ab cd", done, timeout, hi, lo);
        end
        mult_done = 1'b0;
        tick();
        checks++;
        if (timeout !== 1'b0 || op_ready !== 1'b1) begin
            failures++;
            $display("FAIL to_race_after: to=%b rdy=%b required 0 1", timeout, op_ready);
        end
    endtask

    task automatic test_reset_mid_op;
        int pulses;
        op_valid = 1'b1; op_sel = 1'b0; op_a = 32'd4; op_b = 32'd4;
        tick();
        op_valid = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        reset = 1'b0;
        tick();
        checks++;
        if (mult_start !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || op_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset: ms=%b hi=%h lo=%h rdy=%b required 0 0 0 1", mult_start, hi, lo, op_ready);
        end
        reset = 1'b1;
        tick();
        // Held op_valid with changing operands while busy must be ignored.
        op_valid = 1'b1; op_sel = 1'b1; op_a = 32'd9; op_b = 32'd4;
        tick();
        op_a = 32'd100; op_b = 32'd7;
        pulses = 0;
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (opa_q !== 32'd9 || opb_q !== 32'd4 || div_start !== 1'b1) begin
            failures++;
            $display("FAIL busy_ignore: opa=%h opb=%h ds=%b required 9 4 1", opa_q, opb_q, div_start);
        end
        div_done = 1'b1; div_hi = 32'd1; div_lo = 32'd2;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done === 1'b1) begin
                pulses++;
                op_valid = 1'b0;
            end
            div_done = 1'b0;
        end
        op_valid = 1'b0;
        checks++;
        if (pulses !== 1 || hi !== 32'd1 || lo !== 32'd2) begin
            failures++;
            $display("FAIL one_done: pulses=%0d hi=%h lo=%h required 1 1 2", pulses, hi, lo);
        end
    endtask

    task automatic test_done_stuck;
        op_valid = 1'b1; op_sel = 1'b0; op_a = 32'd1; op_b = 32'd1;
        tick();
        op_valid = 1'b0;
        mult_done = 1'b1; mult_hi = 32'hAAAA_AAAA; mult_lo = 32'h5555_5555;
        tick();
        checks++;
        if (done !== 1'b1 || hi !== 32'hAAAA_AAAA || lo !== 32'h5555_5555) begin
            failures++;
            $display("FAIL stuck_capture: done=%b hi=%h lo=%h required 1 aaaaaaaa 55555555", done, hi, lo);
        end
        mult_hi = 32'h1234_5678; mult_lo = 32'h8765_4321;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if ({op_ready, busy, done, mult_start} !== 4'b0100 || hi !== 32'hAAAA_AAAA || lo !== 32'h5555_5555) begin
                failures++;
                $display("FAIL stuck_hold: rdy=%b busy=%b done=%b ms=%b hi=%h lo=%h required 0 1 0 0 aaaaaaaa 55555555",
                         op_ready, busy, done, mult_start, hi, lo);
            end
        end
        mult_done = 1'b0;
        tick();
        checks++;
        if (op_ready !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL stuck_release: rdy=%b done=%b required 1 0", op_ready, done);
        end
    endtask

    initial begin
        reset = 1'b0; op_valid = 1'b0; op_sel = 1'b0; op_a = '0; op_b = '0;
        mult_done = 1'b0; mult_hi = '0; mult_lo = '0;
        div_done = 1'b0; div_hi = '0; div_lo = '0;
        test_reset();
        test_mult();
        test_div();
        test_timeout();
        test_reset_mid_op();
        test_done_stuck();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
